// File: rtl/axi_lite_slave_mem.sv
// AXI-Lite slave backed by a DEPTH x 64-bit register memory, with independent write and read FSMs.
// Optional read wait states are enabled by defining AXIL_SLV_READ_WAIT_EN.
module axi_lite_slave_mem #(
    parameter int          DEPTH     = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          READ_WAIT = 2
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic [63:0] awaddr,
    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [2:0]  awprot,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    output logic        bresp,
    input  logic        bready,
    input  logic [63:0] araddr,
    input  logic [3:0]  arid,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [3:0]  rid,
    output logic        rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    function automatic logic addr_legal(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off[2:0] == 3'd0) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

`ifdef AXIL_SLV_READ_WAIT_EN
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;
`else
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RESP = 2'd2
    } r_state_t;
`endif

    w_state_t          w_state_r;
    w_state_t          w_state_next_s;
    logic [63:0]       aw_addr_r;
    logic [63:0]       w_data_r;
    logic [7:0]        w_strb_r;
    logic              bvalid_r;
    logic              bresp_r;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic [63:0]       wr_addr_s;
    logic [63:0]       wr_data_s;
    logic [7:0]        wr_strb_s;
    logic              wr_commit_s;
    logic              wr_legal_s;
    logic [IDX_W-1:0]  wr_idx_s;

    r_state_t          r_state_r;
    r_state_t          r_state_next_s;
    logic              ar_hs_s;
    logic              rd_legal_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [63:0]       rdata_r;
    logic [3:0]        rid_r;
    logic              rresp_r;
    logic              rvalid_r;

    logic [63:0]       mem_r [DEPTH];

    // IDs on the write side and protection bits are accepted but have no effect.
    logic              unused_s;
    assign unused_s = ^{awid, awprot, arprot};

    assign awready = (w_state_r == W_IDLE) || (w_state_r == W_HAVE_W);
    assign wready  = (w_state_r == W_IDLE) || (w_state_r == W_HAVE_AW);
    assign arready = (r_state_r == R_IDLE);
    assign aw_hs_s = awvalid && awready;
    assign w_hs_s  = wvalid && wready;
    assign ar_hs_s = arvalid && arready;

    assign bvalid = bvalid_r;
    assign bresp  = bresp_r;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign rid    = rid_r;
    assign rresp  = rresp_r;

    // Write FSM next-state decode.
    always_comb begin
        w_state_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_next_s = W_RESP;
                end else if (aw_hs_s) begin
                    w_state_next_s = W_HAVE_AW;
                end else if (w_hs_s) begin
                    w_state_next_s = W_HAVE_W;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_s) begin
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_s) begin
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_RESP;
                end
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Commit payload: a handshake on the committing edge bypasses its holding register.
    always_comb begin
        wr_addr_s   = aw_hs_s ? awaddr : aw_addr_r;
        wr_data_s   = w_hs_s ? wdata : w_data_r;
        wr_strb_s   = w_hs_s ? wstrb : w_strb_r;
        wr_commit_s = (w_state_next_s == W_RESP) && (w_state_r != W_RESP);
        wr_legal_s  = addr_legal(wr_addr_s);
        wr_idx_s    = addr_index(wr_addr_s);
    end

    // Write FSM state, holding registers and response.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            w_state_r <= W_IDLE;
            aw_addr_r <= 64'd0;
            w_data_r  <= 64'd0;
            w_strb_r  <= 8'd0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 1'b0;
        end else begin
            w_state_r <= w_state_next_s;
            bvalid_r  <= (w_state_next_s == W_RESP);
            if (aw_hs_s) begin
                aw_addr_r <= awaddr;
            end
            if (w_hs_s) begin
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
            if (wr_commit_s) begin
                bresp_r <= ~wr_legal_s;
            end
        end
    end

    // Memory array with byte-strobed commit.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else if (wr_commit_s && wr_legal_s) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strb_s[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    assign rd_legal_s = addr_legal(araddr);
    assign rd_idx_s   = addr_index(araddr);

`ifdef AXIL_SLV_READ_WAIT_EN
    logic [3:0] rd_cnt_r;

    // Wait-state down-counter, loaded at the AR handshake.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            rd_cnt_r <= 4'd0;
        end else if (ar_hs_s) begin
            rd_cnt_r <= 4'(READ_WAIT);
        end else if (r_state_r == R_WAIT) begin
            rd_cnt_r <= rd_cnt_r - 4'd1;
        end
    end
`endif

    // Read FSM next-state decode.
    always_comb begin
        r_state_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
`ifdef AXIL_SLV_READ_WAIT_EN
                    if (READ_WAIT != 0) begin
                        r_state_next_s = R_WAIT;
                    end else begin
                        r_state_next_s = R_RESP;
                    end
`else
                    r_state_next_s = R_RESP;
`endif
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
`ifdef AXIL_SLV_READ_WAIT_EN
            R_WAIT: begin
                // Leave on the edge that drains the counter to zero.
                if (rd_cnt_r <= 4'd1) begin
                    r_state_next_s = R_RESP;
                end else begin
                    r_state_next_s = R_WAIT;
                end
            end
`endif
            R_RESP: begin
                if (rready) begin
                    r_state_next_s = R_IDLE;
                end else begin
                    r_state_next_s = R_RESP;
                end
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read FSM state and response registers; data is sampled at the AR handshake.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            rdata_r   <= 64'd0;
            rid_r     <= 4'd0;
            rresp_r   <= 1'b0;
        end else begin
            r_state_r <= r_state_next_s;
            rvalid_r  <= (r_state_next_s == R_RESP);
            if (ar_hs_s) begin
                rdata_r <= rd_legal_s ? mem_r[rd_idx_s] : 64'd0;
                rid_r   <= arid;
                rresp_r <= ~rd_legal_s;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem: directed scenarios plus random traffic
// compared against an array-based memory model.
module tb_axi_lite_slave_mem;

    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          RW    = 2;
`ifdef AXIL_SLV_READ_WAIT_EN
    localparam int          EXP_LAT = RW;
`else
    localparam int          EXP_LAT = 0;
`endif

    logic        aclk;
    logic        arst_n;
    logic [63:0] awaddr;
    logic        awvalid;
    logic [3:0]  awid;
    logic [2:0]  awprot;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bresp;
    logic        bready;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        rresp;
    logic        rvalid;
    logic        rready;

    int n_checks;
    int n_bad;
    logic [63:0] ref_mem [DEPTH];

    axi_lite_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_WAIT(RW)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awprot(awprot), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .araddr(araddr), .arid(arid), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [63:0] addr);
        return (addr >= BASE) && ((addr - BASE) % 64'd8 == 64'd0) && ((addr - BASE) / 64'd8 < 64'(DEPTH));
    endfunction

    function automatic int ref_index(input logic [63:0] addr);
        return int'((addr - BASE) / 64'd8);
    endfunction

    task automatic ref_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        if (ref_legal(addr)) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) ref_mem[ref_index(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] addr);
        return ref_legal(addr) ? ref_mem[ref_index(addr)] : 64'd0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // mode 0: AW and W together; 1: W first, AW after gap; 2: AW first, W after gap.
    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int mode, input int gap);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        if (mode == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            tick();
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else if (mode == 1) begin
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
            repeat (gap) begin
                check_eq("wfirst_awready", awready, 1);
                check_eq("wfirst_wready", wready, 0);
                tick();
            end
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end else begin
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
            repeat (gap) begin
                check_eq("awfirst_awready", awready, 0);
                check_eq("awfirst_wready", wready, 1);
                tick();
            end
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end
        check_eq("bvalid_up", bvalid, 1);
        check_eq("bresp", bresp, ref_legal(addr) ? 64'd0 : 64'd1);
        ref_write(addr, data, strb);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("bvalid_down", bvalid, 0);
        check_eq("awready_idle", awready, 1);
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [3:0] id, input int hold);
        logic [63:0] exp_data;
        int lat;
        exp_data = ref_read(addr);
        araddr  = addr;
        arid    = id;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 20) begin
            check_eq("arready_wait", arready, 0);
            tick();
            lat++;
        end
        check_eq("r_latency", 64'(lat), 64'(EXP_LAT));
        check_eq("rdata", rdata, exp_data);
        check_eq("rid", rid, id);
        check_eq("rresp", rresp, ref_legal(addr) ? 64'd0 : 64'd1);
        repeat (hold) begin
            tick();
            check_eq("hold_rvalid", rvalid, 1);
            check_eq("hold_rdata", rdata, exp_data);
            check_eq("hold_rid", rid, id);
            check_eq("hold_arready", arready, 0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_eq("rvalid_down", rvalid, 0);
        check_eq("arready_idle", arready, 1);
    endtask

    initial begin
        logic [63:0] addr;
        logic [63:0] old_val;
        int lat;
        n_checks = 0;
        n_bad    = 0;
        clear_model();
        arst_n = 1'b0;
        awaddr = 64'd0; awvalid = 1'b0; awid = 4'd0; awprot = 3'd0;
        wdata = 64'd0; wstrb = 8'd0; wvalid = 1'b0; bready = 1'b0;
        araddr = 64'd0; arid = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        arst_n = 1'b1;

        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_awready", awready, 1);
        check_eq("rst_wready", wready, 1);
        check_eq("rst_arready", arready, 1);

        axi_write(64'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0);
        axi_read(64'h08, 4'h5, 0);
        check_eq("model_w08", ref_read(64'h08), 64'hDEAD_BEEF_0123_4567);

        axi_write(64'h10, 64'h1111_2222_3333_4444, 8'h0F, 1, 3);
        axi_read(64'h10, 4'h2, 0);
        check_eq("model_w10", ref_read(64'h10), 64'h0000_0000_3333_4444);

        axi_write(64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        axi_read(64'h0C, 4'h7, 0);
        axi_read(64'h78, 4'h1, 0);

        axi_read(64'h00, 4'h9, 5);

        // Commit to 0x18 on the same edge that a read of 0x18 is accepted.
        awaddr  = 64'h18;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        old_val = ref_read(64'h18);
        wdata   = 64'hA5;
        wstrb   = 8'hFF;
        wvalid  = 1'b1;
        araddr  = 64'h18;
        arid    = 4'h3;
        arvalid = 1'b1;
        tick();
        wvalid  = 1'b0;
        arvalid = 1'b0;
        ref_write(64'h18, 64'hA5, 8'hFF);
        check_eq("rbw_bvalid", bvalid, 1);
        lat = 0;
        while (rvalid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("rbw_latency", 64'(lat), 64'(EXP_LAT));
        check_eq("rbw_old_data", rdata, old_val);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        check_eq("rbw_bvalid_down", bvalid, 0);
        check_eq("rbw_rvalid_down", rvalid, 0);
        axi_read(64'h18, 4'h4, 0);

        // Reset while the write FSM holds an address without data.
        axi_write(64'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0);
        awaddr  = 64'h20;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check_eq("have_aw_awready", awready, 0);
        check_eq("have_aw_wready", wready, 1);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        clear_model();
        check_eq("mid_rst_bvalid", bvalid, 0);
        check_eq("mid_rst_awready", awready, 1);
        check_eq("mid_rst_wready", wready, 1);
        tick();
        check_eq("mid_rst_no_resp", bvalid, 0);
        axi_read(64'h20, 4'hA, 0);

        for (int i = 0; i < 60; i++) begin
            addr = BASE + 64'($urandom_range(0, DEPTH + 1)) * 64'd8;
            if ($urandom_range(0, 7) == 0) addr = addr + 64'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(addr, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)));
            end else begin
                axi_read(addr, 4'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI-Lite responder (slave end) backing a word-addressed register memory of DEPTH x 64-bit entries.
- Sits on the slave side of the team's AXI-Lite interface. Serves as the DUT-side target and reference responder for master driver testing.
- Write and read channels run independent FSMs. A write and a read can be in flight at the same time.

Parameters:
- DEPTH, 16, number of 64-bit words; power of two, minimum 2.
- BASE_ADDR, 64'h0, byte address of word 0; must be 8-byte aligned.
- READ_WAIT, 2, extra read wait cycles; used only when AXIL_SLV_READ_WAIT_EN is defined; range 0-15.

Ports:
- aclk  in  1  clock; all logic on posedge.
- arst_n  in  1  reset; synchronous, active-low.
- awaddr  in  64  write byte address.
- awvalid  in  1  write address valid.
- awid  in  4  write ID; accepted but not echoed, since the interface has no bid.
- awprot  in  3  ignored.
- awready  out  1  write address ready.
- wdata  in  64  write data.
- wstrb  in  8  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bvalid  out  1  write response valid.
- bresp  out  1  0 = OKAY, 1 = SLVERR.
- bready  in  1  write response ready.
- araddr  in  64  read byte address.
- arid  in  4  read ID.
- arprot  in  3  ignored.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  64  read data.
- rid  out  4  echoed arid.
- rresp  out  1  0 = OKAY, 1 = SLVERR.
- rvalid  out  1  read valid.
- rready  in  1  read ready.

Behaviour:
- Reset (arst_n low at posedge):
  - Both FSMs go to idle.
  - bvalid, rvalid, bresp, rresp, rid and rdata go to 0.
  - All memory words are cleared to 0.
  - awready, wready and arready are 1 while the FSMs are idle; they are combinational from FSM state.
  - A reset mid-transaction abandons it: no write commit and no response.
- Address decode:
  - off = addr - BASE_ADDR.
  - Legal when addr >= BASE_ADDR, off[2:0] == 0 and off < DEPTH*8.
  - Word index = off[3 +: log2(DEPTH)].
  - An illegal address gives resp = 1. An illegal write changes no memory. An illegal read returns rdata = 0.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready = 1 in W_IDLE and W_HAVE_W.
  - wready = 1 in W_IDLE and W_HAVE_AW.
  - Each AW or W handshake captures its payload into a holding register.
  - From W_IDLE: AW and W in the same cycle -> W_RESP. AW only -> W_HAVE_AW. W only -> W_HAVE_W.
  - In W_HAVE_AW or W_HAVE_W, the missing handshake -> W_RESP.
  - On the edge entering W_RESP, memory commits the strobed bytes. Bytes with wstrb = 0 keep their old value.
  - Also on that edge, bvalid <= 1 and bresp is set from decode.
  - Latency: both handshakes at edge N -> bvalid high from edge N onward. The new data is visible to any read accepted after edge N.
  - In W_RESP, bvalid and bresp hold stable until bready is seen at a posedge. Then bvalid <= 0 -> W_IDLE.
  - No new AW or W is accepted during W_RESP.
- Read FSM states: R_IDLE, R_WAIT (feature only), R_RESP.
  - arready = 1 only in R_IDLE.
  - At an AR handshake, the memory word, rresp and rid are registered and the FSM goes to R_RESP with rvalid <= 1.
  - Latency: AR handshake at edge N -> rvalid high from edge N onward.
  - rdata, rid and rresp hold stable while rvalid = 1 and rready = 0.
  - rready at a posedge -> rvalid <= 0 -> R_IDLE.
- Same-edge read and write commit to the same word: the read returns the OLD data (read-before-write).
- awid is accepted but not returned.

Optional Feature:
- Macro: AXIL_SLV_READ_WAIT_EN.
- Defined:
  - An AR handshake goes to R_WAIT and loads a 4-bit down-counter with READ_WAIT.
  - The FSM stays in R_WAIT, with rvalid = 0 and arready = 0, until the counter reaches 0, then goes to R_RESP.
  - rvalid rises READ_WAIT cycles later than the base latency.
  - Read data is still sampled at the AR handshake.
  - READ_WAIT = 0 behaves identically to the macro being undefined.
- Undefined: no R_WAIT state or counter; base latency applies.

Test Plan:
- Write 64'hDEAD_BEEF_0123_4567 to 0x08 with wstrb 8'hFF, AW and W in the same cycle, bready = 1 -> bvalid for exactly one cycle with bresp 0. Then read 0x08 with arid 4'h5 -> rdata 64'hDEAD_BEEF_0123_4567, rid 5, rresp 0.
- W sent 3 cycles before AW at 0x10, wstrb 8'h0F, data 64'h1111_2222_3333_4444 -> awready stays high and wready low until AW arrives. A read of 0x10 then returns 64'h0000_0000_3333_4444.
- Write to 0x80 with DEPTH = 16, and read of 0x0C (misaligned) -> bresp 1 with memory unchanged; rresp 1 with rdata 0.
- Read of 0x00 with rready held low for 5 cycles -> rvalid, rdata and rid stable all 5 cycles, and arready stays 0 until the read completes.
- Write commit to 0x18 with new data 64'hA5 on the same edge as a read of 0x18 holding old data 0 -> read returns 0; a following read returns 64'hA5.
- Assert arst_n = 0 during W_HAVE_AW -> next cycle bvalid = 0 and awready = wready = 1; a read of that address returns 0. With AXIL_SLV_READ_WAIT_EN defined and READ_WAIT = 2, rvalid rises exactly 2 cycles later than without the macro.
